// File: rtl/ddr2_host_port.sv
// Host-side front end for ddr2_controller: sequences initialization, issues scalar
// read/write commands under notfull flow control and drains returned read data.
module ddr2_host_port #(
   parameter logic [2:0] CMD_NOP      = 3'b000,
   parameter logic [2:0] CMD_SCR      = 3'b001,
   parameter logic [2:0] CMD_SCW      = 3'b010,
   parameter int          MAX_OUTST    = 8,
   parameter int          RD_LAT       = 1,
   parameter int          INIT_TIMEOUT = 20000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        h_valid,
   output logic        h_ready,
   input  logic        h_we,
   input  logic [24:0] h_addr,
   input  logic [15:0] h_wdata,
   output logic        r_valid,
   input  logic        r_ready,
   output logic [15:0] r_data,
   output logic [24:0] r_addr,
   output logic        init_done,
   output logic        init_err,
   output logic        ctl_initddr,
   output logic [2:0]  ctl_cmd,
   output logic [24:0] ctl_addr,
   output logic [15:0] ctl_din,
   output logic        ctl_read,
   input  logic        ctl_ready,
   input  logic        ctl_notfull,
   input  logic [6:0]  ctl_fillcount,
   input  logic [15:0] ctl_dout,
   input  logic [24:0] ctl_raddr,
   output logic [1:0]  dbg_state,
   output logic [6:0]  dbg_outst
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_INIT = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int IW = $clog2(INIT_TIMEOUT + 1);

   logic [1:0]        state;
   logic [IW-1:0]     init_cnt;
   logic [OW-1:0]     outst;
   logic [RD_LAT-1:0] pop_pipe;
   logic              accept;
   logic              rd_accept;
   logic              capture;
   logic              cap_dec;

   // Handshakes: a transfer happens on a clock edge where valid and ready are both
   // high; valid never waits on ready, and ready may depend combinationally on valid-side
   // fields (h_we) but the payload must be held stable until the transfer completes.
   assign h_ready   = (state == ST_RUN) & ctl_notfull & (h_we | (outst < OW'(MAX_OUTST)));
   assign accept    = h_valid & h_ready;
   assign rd_accept = accept & ~h_we;

   // A pop is only launched when the response register is guaranteed free at capture.
   assign ctl_read  = (state == ST_RUN) & (ctl_fillcount != 7'd0) & ~(|pop_pipe) &
                      (~r_valid | r_ready);
   assign capture   = pop_pipe[RD_LAT-1];
   assign cap_dec   = capture & (outst != '0);

   assign ctl_initddr = (state == ST_INIT) | (state == ST_RUN);
   assign init_done   = (state == ST_RUN);
   assign init_err    = (state == ST_ERR);
   assign dbg_state   = state;
   assign dbg_outst   = 7'(outst);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         init_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               init_cnt <= '0;
               if (start) state <= ST_INIT;
            end
            ST_INIT: begin
               init_cnt <= init_cnt + IW'(1);
               if (ctl_ready)                              state <= ST_RUN;
               else if (init_cnt == IW'(INIT_TIMEOUT - 1)) state <= ST_ERR;
            end
            ST_RUN:  state <= ST_RUN;
            default: state <= ST_ERR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctl_cmd  <= CMD_NOP;
         ctl_addr <= '0;
         ctl_din  <= '0;
      end else if (accept) begin
         ctl_cmd  <= h_we ? CMD_SCW : CMD_SCR;
         ctl_addr <= h_addr;
         ctl_din  <= h_wdata;
      end else begin
         ctl_cmd  <= CMD_NOP;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outst <= '0;
      end else begin
         case ({rd_accept, cap_dec})
            2'b10:   outst <= outst + OW'(1);
            2'b01:   outst <= outst - OW'(1);
            default: outst <= outst;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pop_pipe <= '0;
      end else begin
         pop_pipe[0] <= ctl_read;
         for (int i = 1; i < RD_LAT; i++) pop_pipe[i] <= pop_pipe[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_addr  <= '0;
      end else if (capture) begin
         r_valid <= 1'b1;
         r_data  <= ctl_dout;
         r_addr  <= ctl_raddr;
      end else if (r_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ddr2_host_port.sv
// Directed bench for ddr2_host_port with a small return-FIFO model of the controller.
module tb_ddr2_host_port;

   localparam logic [2:0] CMD_NOP = 3'b000;
   localparam logic [2:0] CMD_SCR = 3'b001;
   localparam logic [2:0] CMD_SCW = 3'b010;
   localparam int INIT_TIMEOUT = 20000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        h_valid = 1'b0;
   logic        h_ready;
   logic        h_we = 1'b0;
   logic [24:0] h_addr = '0;
   logic [15:0] h_wdata = '0;
   logic        r_valid;
   logic        r_ready = 1'b0;
   logic [15:0] r_data;
   logic [24:0] r_addr;
   logic        init_done;
   logic        init_err;
   logic        ctl_initddr;
   logic [2:0]  ctl_cmd;
   logic [24:0] ctl_addr;
   logic [15:0] ctl_din;
   logic        ctl_read;
   logic        ctl_ready = 1'b0;
   logic        ctl_notfull = 1'b1;
   logic [6:0]  ctl_fillcount;
   logic [15:0] ctl_dout = '0;
   logic [24:0] ctl_raddr = '0;
   logic [1:0]  dbg_state;
   logic [6:0]  dbg_outst;

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0] ret_data [0:63];
   logic [24:0] ret_addr [0:63];
   int          push_cnt = 0;
   int          pop_cnt = 0;
   logic [15:0] exp_q [$];
   logic [24:0] exp_a [$];

   always #5 clk = ~clk;

   ddr2_host_port dut (
      .clk(clk), .reset(reset), .start(start),
      .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_addr(r_addr),
      .init_done(init_done), .init_err(init_err), .ctl_initddr(ctl_initddr),
      .ctl_cmd(ctl_cmd), .ctl_addr(ctl_addr), .ctl_din(ctl_din), .ctl_read(ctl_read),
      .ctl_ready(ctl_ready), .ctl_notfull(ctl_notfull), .ctl_fillcount(ctl_fillcount),
      .ctl_dout(ctl_dout), .ctl_raddr(ctl_raddr), .dbg_state(dbg_state), .dbg_outst(dbg_outst)
   );

   // Controller return FIFO: fillcount tracks queued entries, dout is valid one cycle after a pop.
   assign ctl_fillcount = 7'(push_cnt - pop_cnt);
   always @(posedge clk) begin
      if (ctl_read) begin
         ctl_dout  <= ret_data[pop_cnt];
         ctl_raddr <= ret_addr[pop_cnt];
         pop_cnt   <= pop_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ret(input logic [15:0] d, input logic [24:0] a);
      ret_data[push_cnt] = d;
      ret_addr[push_cnt] = a;
      push_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b0; h_valid = 1'b1; h_we = 1'b1;
      repeat (3) tick();
      tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
      tests_run++; if (ctl_cmd !== CMD_NOP) begin tests_failed++; $display("FAIL rst_cmd: got %0h exp %0h", ctl_cmd, CMD_NOP); end
      tests_run++; if ({init_done, init_err, ctl_initddr, r_valid, ctl_read} !== 5'b0) begin
         tests_failed++; $display("FAIL rst_flags: got %b exp 00000", {init_done, init_err, ctl_initddr, r_valid, ctl_read}); end
      tests_run++; if (h_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_h_ready: got %b exp 0", h_ready); end
      h_valid = 1'b0; h_we = 1'b0;
   endtask

   task automatic test_init();
      reset = 1'b1;
      tick();
      start = 1'b1;
      tick();
      tests_run++; if (ctl_initddr !== 1'b1) begin tests_failed++; $display("FAIL init_initddr: got %b exp 1", ctl_initddr); end
      tests_run++; if (dbg_state !== 2'd1) begin tests_failed++; $display("FAIL init_state: got %0d exp 1", dbg_state); end
      start = 1'b0;
      repeat (298) tick();
      tests_run++; if ({init_done, init_err} !== 2'b00) begin tests_failed++; $display("FAIL init_early: got %b exp 00", {init_done, init_err}); end
      tick();
      ctl_ready = 1'b1;
      #1;
      tests_run++; if (init_done !== 1'b0) begin tests_failed++; $display("FAIL init_done_same: got %b exp 0", init_done); end
      tick();
      tests_run++; if (init_done !== 1'b1) begin tests_failed++; $display("FAIL init_done: got %b exp 1", init_done); end
      tests_run++; if (ctl_initddr !== 1'b1) begin tests_failed++; $display("FAIL init_initddr_run: got %b exp 1", ctl_initddr); end
      tests_run++; if (h_ready !== 1'b1) begin tests_failed++; $display("FAIL init_h_ready: got %b exp 1", h_ready); end
   endtask

   task automatic test_write();
      h_valid = 1'b1; h_we = 1'b1; h_addr = 25'h0000ABC; h_wdata = 16'hBEEF;
      #1;
      tests_run++; if (h_ready !== 1'b1) begin tests_failed++; $display("FAIL wr_h_ready: got %b exp 1", h_ready); end
      tick();
      h_valid = 1'b0;
      tests_run++; if (ctl_cmd !== CMD_SCW) begin tests_failed++; $display("FAIL wr_cmd: got %0h exp %0h", ctl_cmd, CMD_SCW); end
      tests_run++; if (ctl_addr !== 25'h0000ABC) begin tests_failed++; $display("FAIL wr_addr: got %h exp 0000abc", ctl_addr); end
      tests_run++; if (ctl_din !== 16'hBEEF) begin tests_failed++; $display("FAIL wr_din: got %h exp beef", ctl_din); end
      tick();
      tests_run++; if (ctl_cmd !== CMD_NOP) begin tests_failed++; $display("FAIL wr_cmd_after: got %0h exp %0h", ctl_cmd, CMD_NOP); end
      tests_run++; if (ctl_addr !== 25'h0000ABC) begin tests_failed++; $display("FAIL wr_addr_hold: got %h exp 0000abc", ctl_addr); end
   endtask

   task automatic test_read();
      int p0;
      h_valid = 1'b1; h_we = 1'b0; h_addr = 25'h0000ABC; h_wdata = 16'h0000;
      tick();
      h_valid = 1'b0;
      tests_run++; if (ctl_cmd !== CMD_SCR) begin tests_failed++; $display("FAIL rd_cmd: got %0h exp %0h", ctl_cmd, CMD_SCR); end
      tests_run++; if (dbg_outst !== 7'd1) begin tests_failed++; $display("FAIL rd_outst1: got %0d exp 1", dbg_outst); end
      p0 = pop_cnt;
      push_ret(16'hBEEF, 25'h0000ABC);
      #1;
      tests_run++; if (ctl_read !== 1'b1) begin tests_failed++; $display("FAIL rd_pop: got %b exp 1", ctl_read); end
      tick();
      tests_run++; if ({ctl_read, r_valid} !== 2'b00) begin tests_failed++; $display("FAIL rd_wait: got %b exp 00", {ctl_read, r_valid}); end
      tick();
      tests_run++; if (r_valid !== 1'b1) begin tests_failed++; $display("FAIL rd_rvalid: got %b exp 1", r_valid); end
      tests_run++; if (r_data !== 16'hBEEF) begin tests_failed++; $display("FAIL rd_data: got %h exp beef", r_data); end
      tests_run++; if (r_addr !== 25'h0000ABC) begin tests_failed++; $display("FAIL rd_raddr: got %h exp 0000abc", r_addr); end
      tests_run++; if (dbg_outst !== 7'd0) begin tests_failed++; $display("FAIL rd_outst0: got %0d exp 0", dbg_outst); end
      tests_run++; if (pop_cnt - p0 !== 1) begin tests_failed++; $display("FAIL rd_pop_count: got %0d exp 1", pop_cnt - p0); end
      r_ready = 1'b1;
      tick();
      tests_run++; if (r_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_drained: got %b exp 0", r_valid); end
      r_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      h_valid = 1'b1; h_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         h_addr = 25'h200 + 25'(i);
         #1;
         tests_run++; if (h_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_read_%0d: got %b exp 1", i, h_ready); end
         tick();
      end
      h_addr = 25'h208;
      #1;
      tests_run++; if (h_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ninth: got %b exp 0", h_ready); end
      tests_run++; if (dbg_outst !== 7'd8) begin tests_failed++; $display("FAIL bp_outst8: got %0d exp 8", dbg_outst); end
      tick();
      tests_run++; if (ctl_cmd !== CMD_NOP) begin tests_failed++; $display("FAIL bp_no_cmd: got %0h exp %0h", ctl_cmd, CMD_NOP); end
      h_we = 1'b1; h_wdata = 16'h1234;
      #1;
      tests_run++; if (h_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_write_ok: got %b exp 1", h_ready); end
      tick();
      ctl_notfull = 1'b0;
      tests_run++; if (ctl_cmd !== CMD_SCW) begin tests_failed++; $display("FAIL bp_write_cmd: got %0h exp %0h", ctl_cmd, CMD_SCW); end
      #1;
      tests_run++; if (h_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_wr: got %b exp 0", h_ready); end
      h_we = 1'b0;
      #1;
      tests_run++; if (h_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_rd: got %b exp 0", h_ready); end
      tick();
      tests_run++; if (ctl_cmd !== CMD_NOP) begin tests_failed++; $display("FAIL bp_full_cmd: got %0h exp %0h", ctl_cmd, CMD_NOP); end
      h_valid = 1'b0; ctl_notfull = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push_ret(16'hD000 + 16'(i), 25'h200 + 25'(i));
         exp_q.push_back(16'hD000 + 16'(i));
         exp_a.push_back(25'h200 + 25'(i));
      end
      r_ready = 1'b1;
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
         if (r_valid) begin
            tests_run++; if (r_data !== exp_q[0] || r_addr !== exp_a[0]) begin tests_failed++;
               $display("FAIL bp_drain: got %h@%h exp %h@%h", r_data, r_addr, exp_q[0], exp_a[0]); end
            void'(exp_q.pop_front()); void'(exp_a.pop_front());
         end
         tick();
      end
      tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL bp_drain_timeout: got %0d left exp 0", exp_q.size()); end
      tests_run++; if (dbg_outst !== 7'd0) begin tests_failed++; $display("FAIL bp_outst0: got %0d exp 0", dbg_outst); end
      r_ready = 1'b0;
      exp_q.delete(); exp_a.delete();
   endtask

   task automatic test_hold();
      int p0;
      h_valid = 1'b1; h_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         h_addr = 25'h100 + 25'(i);
         tick();
      end
      h_valid = 1'b0;
      p0 = pop_cnt;
      for (int i = 0; i < 3; i++) begin
         push_ret(16'hC000 + 16'(i), 25'h100 + 25'(i));
         exp_q.push_back(16'hC000 + 16'(i));
         exp_a.push_back(25'h100 + 25'(i));
      end
      repeat (10) tick();
      tests_run++; if (pop_cnt - p0 !== 1) begin tests_failed++; $display("FAIL hold_pops: got %0d exp 1", pop_cnt - p0); end
      tests_run++; if (r_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_rvalid: got %b exp 1", r_valid); end
      for (int c = 0; c < 3; c++) begin
         tests_run++; if (r_data !== 16'hC000 || r_addr !== 25'h100) begin tests_failed++;
            $display("FAIL hold_stable: got %h@%h exp c000@0000100", r_data, r_addr); end
         tick();
      end
      r_ready = 1'b1;
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
         if (r_valid) begin
            tests_run++; if (r_data !== exp_q[0] || r_addr !== exp_a[0]) begin tests_failed++;
               $display("FAIL hold_drain: got %h@%h exp %h@%h", r_data, r_addr, exp_q[0], exp_a[0]); end
            void'(exp_q.pop_front()); void'(exp_a.pop_front());
         end
         tick();
      end
      tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL hold_drain_timeout: got %0d left exp 0", exp_q.size()); end
      tests_run++; if (pop_cnt - p0 !== 3) begin tests_failed++; $display("FAIL hold_total_pops: got %0d exp 3", pop_cnt - p0); end
      tests_run++; if (dbg_outst !== 7'd0) begin tests_failed++; $display("FAIL hold_outst0: got %0d exp 0", dbg_outst); end
      r_ready = 1'b0;
      exp_q.delete(); exp_a.delete();
   endtask

   task automatic test_reset_mid_run();
      h_valid = 1'b1; h_we = 1'b0; h_addr = 25'h1234;
      tick();
      h_valid = 1'b0;
      push_ret(16'h5A5A, 25'h1234);
      repeat (3) tick();
      tests_run++; if (r_valid !== 1'b1 || r_data !== 16'h5A5A) begin tests_failed++;
         $display("FAIL mid_pre_rvalid: got %b/%h exp 1/5a5a", r_valid, r_data); end
      h_valid = 1'b1; h_we = 1'b1; h_addr = 25'h0777; h_wdata = 16'h7777;
      tick();
      h_valid = 1'b0;
      tests_run++; if (ctl_cmd !== CMD_SCW) begin tests_failed++; $display("FAIL mid_pre_cmd: got %0h exp %0h", ctl_cmd, CMD_SCW); end
      #2;
      reset = 1'b0;
      #1;
      tests_run++; if ({r_valid, ctl_read, ctl_initddr, init_done, h_ready} !== 5'b0) begin tests_failed++;
         $display("FAIL mid_flags: got %b exp 00000", {r_valid, ctl_read, ctl_initddr, init_done, h_ready}); end
      tests_run++; if (ctl_cmd !== CMD_NOP || ctl_addr !== 25'h0 || ctl_din !== 16'h0) begin tests_failed++;
         $display("FAIL mid_ctl: got %0h/%h/%h exp 0/0/0", ctl_cmd, ctl_addr, ctl_din); end
      tests_run++; if (r_data !== 16'h0 || dbg_state !== 2'd0) begin tests_failed++;
         $display("FAIL mid_state: got %h/%0d exp 0/0", r_data, dbg_state); end
   endtask

   task automatic test_timeout();
      ctl_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (INIT_TIMEOUT - 1) tick();
      tests_run++; if (init_err !== 1'b0 || dbg_state !== 2'd1) begin tests_failed++;
         $display("FAIL to_early: got %b/%0d exp 0/1", init_err, dbg_state); end
      tick();
      tests_run++; if (init_err !== 1'b1 || dbg_state !== 2'd3) begin tests_failed++;
         $display("FAIL to_err: got %b/%0d exp 1/3", init_err, dbg_state); end
      h_valid = 1'b1; h_we = 1'b1; ctl_notfull = 1'b1;
      #1;
      tests_run++; if (h_ready !== 1'b0) begin tests_failed++; $display("FAIL to_h_ready: got %b exp 0", h_ready); end
      ctl_ready = 1'b1;
      tick();
      tick();
      tests_run++; if (init_done !== 1'b0 || init_err !== 1'b1) begin tests_failed++;
         $display("FAIL to_sticky: got %b/%b exp 0/1", init_done, init_err); end
      h_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_init();
      test_write();
      test_read();
      test_backpressure();
      test_hold();
      test_reset_mid_run();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ddr2_host_port.md
Name: ddr2_host_port

Overview:
- Upstream front-end for ddr2_controller; sits between a simple valid/ready host and the controller's cmd/addr/din/read interface.
- Sequences DDR2 initialization (initddr until ready), then issues scalar read/write commands while honouring notfull.
- Drains returned read data via the read/fillcount interface into a host response handshake.

Parameters:
- CMD_NOP, 3'b000, controller idle command
- CMD_SCR, 3'b001, controller scalar-read command
- CMD_SCW, 3'b010, controller scalar-write command
- MAX_OUTST, 8, max reads issued but not yet returned (1..64)
- RD_LAT, 1, cycles from ctl_read pulse to valid ctl_dout/ctl_raddr (1..3)
- INIT_TIMEOUT, 20000, cycles allowed for ctl_ready after initddr asserted

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-low reset
- start, input, 1, level; begins init sequence
- h_valid, input, 1, host request valid
- h_ready, output, 1, host request accepted this cycle when high with h_valid
- h_we, input, 1, 1=write, 0=read
- h_addr, input, 25, request address
- h_wdata, input, 16, write data
- r_valid, output, 1, read response valid
- r_ready, input, 1, host accepts response
- r_data, output, 16, read data
- r_addr, output, 25, address of returned data
- init_done, output, 1, controller initialized
- init_err, output, 1, init timeout (sticky)
- ctl_initddr, output, 1, to controller initddr
- ctl_cmd, output, 3, to controller cmd
- ctl_addr, output, 25, to controller addr
- ctl_din, output, 16, to controller din
- ctl_read, output, 1, to controller read (pop return FIFO)
- ctl_ready, input, 1, from controller ready
- ctl_notfull, input, 1, from controller notfull
- ctl_fillcount, input, 7, from controller fillcount
- ctl_dout, input, 16, from controller dout
- ctl_raddr, input, 25, from controller raddr

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; ctl_cmd=CMD_NOP; counters cleared; init_err cleared.
- States: IDLE -> INIT when start=1; INIT drives ctl_initddr=1 and counts; INIT -> RUN on first cycle ctl_ready=1 (init_done=1 next cycle, ctl_initddr stays 1); INIT -> ERR when count reaches INIT_TIMEOUT without ready (init_err=1). ERR holds until reset. RUN is terminal.
- h_ready = (state==RUN) & ctl_notfull & (h_we | outst<MAX_OUTST). Combinational.
- Accept (h_valid&h_ready): next cycle ctl_cmd=SCW/SCR, ctl_addr/ctl_din registered from h_*, for exactly one cycle; otherwise ctl_cmd=CMD_NOP, ctl_addr/ctl_din hold last values. Back-to-back accepts allowed (one command per cycle).
- outst: +1 on read accept, -1 on response capture; both same cycle -> unchanged; never exceeds MAX_OUTST.
- Return path: one-entry response register plus pop-in-flight tracker. ctl_read pulses one cycle when RUN & ctl_fillcount!=0 & no pop in flight & (response register empty or being drained this cycle). Exactly RD_LAT cycles later capture ctl_dout/ctl_raddr into r_data/r_addr, r_valid=1.
- r_valid clears on r_valid&r_ready unless a capture occurs same cycle (then stays 1 with new data). r_data/r_addr stable while r_valid=1 & r_ready=0.
- Pop spacing: at most one ctl_read per RD_LAT+1 cycles; no read data is ever dropped.
- Reset mid-operation: immediate return to IDLE, outstanding and pending responses discarded.
- start deasserted after INIT entered: ignored.

Test Plan:
- Reset then start=1, ctl_ready rises 300 cycles later -> ctl_initddr=1 from cycle after start, init_done=1 one cycle after ready, h_ready=1 with ctl_notfull=1.
- Write h_addr=25'h0000ABC, h_wdata=16'hBEEF -> next cycle ctl_cmd=3'b010, ctl_addr=25'h0000ABC, ctl_din=16'hBEEF for one cycle, then CMD_NOP.
- Read of 25'h0000ABC, controller model returns fillcount=1, dout=16'hBEEF -> single ctl_read pulse, after RD_LAT r_valid=1, r_data=16'hBEEF, r_addr=25'h0000ABC; outst returns to 0.
- Issue 8 reads with no returns -> ninth read sees h_ready=0 while a write with ctl_notfull=1 is still accepted; ctl_notfull=0 blocks all accepts.
- Hold r_ready=0 with fillcount=3 -> only one ctl_read until response drained; then remaining two returned in order, none lost.
- start=1, ctl_ready never rises -> init_err=1 at INIT_TIMEOUT, h_ready stays 0; reset low mid-RUN clears r_valid and all ctl outputs asynchronously.
